// File: rtl/umi_xform_pkg.sv
// UMI packet transform shared types.
// Mode encoding and the per-word transform helper.
package umi_xform_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_ADD  = 2'd1,
        MODE_SUB  = 2'd2,
        MODE_DROP = 2'd3
    } mode_t;

    // Widest lane the helper supports; callers size-cast in and out.
    localparam int XW = 64;

    function automatic logic [XW-1:0] xform_word(
        input mode_t          m,
        input logic [XW-1:0]  w,
        input logic [XW-1:0]  incr
    );
        logic [XW-1:0] r;
        r = w;
        case (m)
            MODE_ADD: r = w + incr;
            MODE_SUB: r = w - incr;
            default:  r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/umi_xform_fifo.sv
// Synchronous FIFO with registered storage and occupancy count.
// Full/empty come from the level, pointers wrap modulo DEPTH.
module umi_xform_fifo #(
    parameter int W     = 256,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/umi_packet_xform.sv
// UMI packet transform stage: per-lane PASS/ADD/SUB/DROP,
// FIFO-buffered output and packet counters.
module umi_packet_xform
    import umi_xform_pkg::*;
#(
    parameter int          PW    = 256,
    parameter int          WW    = 32,
    parameter int          DEPTH = 4,
    parameter int unsigned INCR  = 1,
    parameter int          CW    = 32
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [1:0]              mode,
    input  logic [PW-1:0]           in_packet,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [PW-1:0]           out_packet,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW-1:0]           in_count,
    output logic [CW-1:0]           out_count,
    output logic [CW-1:0]           drop_count,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int NW = PW / WW;

    mode_t         m;
    logic [PW-1:0] xf;
    logic          rdy_q;
    logic          full;
    logic          empty;
    logic          acc;
    logic          push;
    logic          pop;

    assign m = mode_t'(mode);

    for (genvar i = 0; i < NW; i++) begin : g_lane
        assign xf[i*WW +: WW] = WW'(xform_word(
            m, XW'(in_packet[i*WW +: WW]), XW'(INCR)));
    end

    assign in_ready  = rdy_q && !full;
    assign out_valid = !empty;
    assign acc       = in_valid && in_ready;
    assign push      = acc && (m != MODE_DROP);
    assign pop       = out_valid && out_ready;

    // Input ready comes up on the first edge after reset release.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Free-running wrap-around packet counters.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_count   <= '0;
            out_count  <= '0;
            drop_count <= '0;
        end else begin
            if (acc) begin
                in_count <= in_count + CW'(1);
            end
            if (pop) begin
                out_count <= out_count + CW'(1);
            end
            if (acc && (m == MODE_DROP)) begin
                drop_count <= drop_count + CW'(1);
            end
        end
    end

    umi_xform_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .din    (xf),
        .pop    (pop),
        .dout   (out_packet),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

endmodule
